// File: rtl/ex_stage.sv
// ex_stage: ARM execute stage; builds operand 2, runs the ALU, computes the branch target and owns the NZCV register.
//   in : clk, rst (sync, active-high), ID/EX controls, EX_command_in, status_register_in, operands, pc_in, immediates
//   out: alu_result, branch_address, branch_taken, status_register (registered), pass-through controls/dst/val_Rm
module ex_stage #(
  parameter int WORD_WIDTH            = 32,
  parameter int REG_FILE_DEPTH        = 4,
  parameter int SIGNED_IMM_WIDTH      = 24,
  parameter int SHIFTER_OPERAND_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       EX_command_in,
  input  logic                             mem_read_in,
  input  logic                             mem_write_in,
  input  logic                             WB_en_in,
  input  logic                             Imm_in,
  input  logic                             B_in,
  input  logic                             SR_update_in,
  input  logic [3:0]                       status_register_in,
  input  logic [REG_FILE_DEPTH-1:0]        reg_file_dst_in,
  input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [WORD_WIDTH-1:0]            val_Rn_in,
  input  logic [WORD_WIDTH-1:0]            val_Rm_in,
  output logic [WORD_WIDTH-1:0]            alu_result,
  output logic [WORD_WIDTH-1:0]            branch_address,
  output logic                             branch_taken,
  output logic [3:0]                       status_register,
  output logic                             mem_read_out,
  output logic                             mem_write_out,
  output logic                             WB_en_out,
  output logic [REG_FILE_DEPTH-1:0]        reg_file_dst_out,
  output logic [WORD_WIDTH-1:0]            val_Rm_out
);
  localparam int MSB = WORD_WIDTH - 1;

  function automatic logic [WORD_WIDTH-1:0] ror(input logic [WORD_WIDTH-1:0] x, input logic [4:0] r);
    return (x >> r) | (x << (WORD_WIDTH - 32'(r)));
  endfunction

  logic [WORD_WIDTH-1:0] imm_rot, rm_asr, rm_shift, val2, b_op, result;
  logic [WORD_WIDTH:0]   sum;
  logic [1:0]            sh_type;
  logic [4:0]            sh_amt;
  logic                  arith, sub, cin, valid, c_f, v_f;
  logic [3:0]            flags, status_register_d, status_register_q;

  always_comb begin
    imm_rot  = ror({{(WORD_WIDTH-8){1'b0}}, shifter_operand_in[7:0]}, {shifter_operand_in[11:8], 1'b0});
    sh_amt   = shifter_operand_in[11:7];
    sh_type  = shifter_operand_in[6:5];
    // kept separate so the signed shift is not turned logical by a mixed-sign ternary
    rm_asr   = $signed(val_Rm_in) >>> sh_amt;
    rm_shift = sh_type == 2'b00 ? val_Rm_in << sh_amt :
               sh_type == 2'b01 ? val_Rm_in >> sh_amt :
               sh_type == 2'b10 ? rm_asr : ror(val_Rm_in, sh_amt);
    val2     = Imm_in ? imm_rot :
               (mem_read_in | mem_write_in) ? {{(WORD_WIDTH-SHIFTER_OPERAND_WIDTH){1'b0}}, shifter_operand_in} :
               rm_shift;
    arith    = EX_command_in inside {4'd2, 4'd3, 4'd4, 4'd5};
    sub      = EX_command_in inside {4'd4, 4'd5};
    valid    = arith | (EX_command_in inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9});
    // SUB forces the +1 of two's complement; ADC/SBC take the incoming carry
    cin      = (EX_command_in == 4'd4) | ((EX_command_in inside {4'd3, 4'd5}) & status_register_in[1]);
    b_op     = sub ? ~val2 : val2;
    sum      = {1'b0, val_Rn_in} + {1'b0, b_op} + {{WORD_WIDTH{1'b0}}, cin};
    result   = arith                  ? sum[MSB:0] :
               EX_command_in == 4'd1  ? val2 :
               EX_command_in == 4'd9  ? ~val2 :
               EX_command_in == 4'd6  ? val_Rn_in & val2 :
               EX_command_in == 4'd7  ? val_Rn_in | val2 :
               EX_command_in == 4'd8  ? val_Rn_in ^ val2 : '0;
    c_f      = arith ? sum[WORD_WIDTH] : status_register_in[1];
    v_f      = arith ? (val_Rn_in[MSB] == b_op[MSB]) & (result[MSB] != val_Rn_in[MSB]) : status_register_in[0];
    // undefined opcodes report the flags they came in with
    flags    = valid ? {result[MSB], result == '0, c_f, v_f} : status_register_in;
    status_register_d = SR_update_in ? flags : status_register_q;
  end

  always_ff @(posedge clk) begin
    if (rst) status_register_q <= 4'b0000;
    else     status_register_q <= status_register_d;
  end

  assign alu_result       = result;
  assign branch_address   = pc_in + {{(WORD_WIDTH-SIGNED_IMM_WIDTH-2){signed_immediate_in[SIGNED_IMM_WIDTH-1]}},
                                     signed_immediate_in, 2'b00};
  assign branch_taken     = B_in;
  assign status_register  = status_register_q;
  assign mem_read_out     = mem_read_in;
  assign mem_write_out    = mem_write_in;
  assign WB_en_out        = WB_en_in;
  assign reg_file_dst_out = reg_file_dst_in;
  assign val_Rm_out       = val_Rm_in;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cmd;
  logic        mem_read, mem_write, wb_en, imm, b, sr_upd;
  logic [3:0]  sr_in;
  logic [3:0]  dst;
  logic [23:0] simm;
  logic [11:0] sop;
  logic [31:0] pc, rn, rm;
  logic [31:0] alu_result, branch_address, val_Rm_out;
  logic        branch_taken, mem_read_out, mem_write_out, WB_en_out;
  logic [3:0]  status_register, reg_file_dst_out;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .EX_command_in(cmd),
    .mem_read_in(mem_read), .mem_write_in(mem_write), .WB_en_in(wb_en),
    .Imm_in(imm), .B_in(b), .SR_update_in(sr_upd), .status_register_in(sr_in),
    .reg_file_dst_in(dst), .signed_immediate_in(simm), .shifter_operand_in(sop),
    .pc_in(pc), .val_Rn_in(rn), .val_Rm_in(rm),
    .alu_result(alu_result), .branch_address(branch_address), .branch_taken(branch_taken),
    .status_register(status_register), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .WB_en_out(WB_en_out), .reg_file_dst_out(reg_file_dst_out), .val_Rm_out(val_Rm_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] c, input logic i, input logic [11:0] s, input logic [31:0] a, input logic [31:0] m);
    @(negedge clk);
    rst = 0; cmd = c; imm = i; sop = s; rn = a; rm = m;
    mem_read = 0; mem_write = 0; wb_en = 0; b = 0; sr_upd = 0; sr_in = 4'b0000;
    dst = 0; simm = 0; pc = 0;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; cmd = 0; imm = 0; sop = 0; rn = 0; rm = 0; mem_read = 0; mem_write = 0;
    wb_en = 0; b = 0; sr_upd = 0; sr_in = 0; dst = 0; simm = 0; pc = 0;
    edge_wait();
    chk("reset_sr", 32'(status_register), 32'h0);

    op(4'd2, 1, 12'h001, 32'h7FFFFFFF, 0); sr_upd = 1; #1;
    chk("add_ovf_res", alu_result, 32'h80000000);
    edge_wait();
    chk("add_ovf_flags", 32'(status_register), 32'b1001);

    op(4'd1, 1, 12'h000, 0, 0); sr_upd = 1; rst = 1; #1;
    edge_wait();
    chk("rst_over_update", 32'(status_register), 32'h0);

    op(4'd4, 1, 12'h007, 32'd5, 0); sr_upd = 1; #1;
    chk("sub_borrow_res", alu_result, 32'hFFFFFFFE);
    edge_wait();
    chk("sub_borrow_flags", 32'(status_register), 32'b1000);

    op(4'd4, 1, 12'h007, 32'd7, 0); sr_upd = 1; #1;
    chk("cmp_eq_res", alu_result, 32'h0);
    edge_wait();
    chk("cmp_eq_flags", 32'(status_register), 32'b0110);

    op(4'd3, 1, 12'h001, 32'd1, 0); sr_in = 4'b0010; #1;
    chk("adc_res", alu_result, 32'd3);
    edge_wait();
    chk("no_update_hold", 32'(status_register), 32'b0110);

    op(4'd5, 1, 12'h001, 32'd1, 0); sr_upd = 1; #1;
    chk("sbc_res", alu_result, 32'hFFFFFFFF);
    edge_wait();
    chk("sbc_flags", 32'(status_register), 32'b1000);

    op(4'd0, 0, 12'h000, 0, 0);
    edge_wait();
    chk("bubble_hold", 32'(status_register), 32'b1000);

    op(4'd1, 1, 12'h4FF, 0, 0);
    chk("imm_rot", alu_result, 32'hFF000000);
    op(4'd1, 0, 12'h240, 0, 32'h80000000);
    chk("asr4", alu_result, 32'hF8000000);
    op(4'd1, 0, 12'h470, 0, 32'h000000AB);
    chk("ror8", alu_result, 32'hAB000000);
    op(4'd1, 0, 12'h200, 0, 32'h0000000F);
    chk("lsl4", alu_result, 32'h000000F0);
    op(4'd1, 0, 12'h220, 0, 32'h000000F0);
    chk("lsr4", alu_result, 32'h0000000F);
    op(4'd2, 0, 12'h000, 32'd1, 32'h12345678);
    chk("shift0_add", alu_result, 32'h12345679);
    op(4'd9, 1, 12'h000, 0, 0);
    chk("mvn", alu_result, 32'hFFFFFFFF);
    op(4'd6, 1, 12'h0FF, 32'h0000F0F0, 0);
    chk("and", alu_result, 32'h000000F0);
    op(4'd7, 1, 12'h0FF, 32'h00000F00, 0);
    chk("orr", alu_result, 32'h00000FFF);
    op(4'd8, 1, 12'h00F, 32'h000000FF, 0);
    chk("eor", alu_result, 32'h000000F0);
    op(4'd15, 1, 12'h0FF, 32'h12345678, 0);
    chk("undef_res", alu_result, 32'h0);

    op(4'd6, 1, 12'h0FF, 32'h0, 0); sr_in = 4'b0011; sr_upd = 1; #1;
    edge_wait();
    chk("tst_keep_cv", 32'(status_register), 32'b0111);

    op(4'd0, 0, 12'h000, 0, 0); pc = 32'h100; simm = 24'hFFFFFE; b = 1; #1;
    chk("branch_addr", branch_address, 32'h000000F8);
    chk("branch_taken1", 32'(branch_taken), 32'd1);
    b = 0; #1;
    chk("branch_taken0", 32'(branch_taken), 32'd0);

    op(4'd2, 0, 12'h00C, 32'h400, 32'hDEADBEEF); mem_write = 1; wb_en = 1; dst = 4'hA; #1;
    chk("mem_addr", alu_result, 32'h40C);
    chk("store_data", val_Rm_out, 32'hDEADBEEF);
    chk("ctrl_pass", {26'd0, mem_read_out, mem_write_out, reg_file_dst_out}, {26'd0, 1'b0, 1'b1, 4'hA});
    chk("wb_pass", 32'(WB_en_out), 32'd1);

    op(4'd2, 1, 12'h001, 32'h7FFFFFFF, 0); sr_upd = 1; rst = 1; #1;
    chk("rst_comb_live", alu_result, 32'h80000000);
    edge_wait();
    chk("rst_discard", 32'(status_register), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
